// File: rtl/mdu_unit.sv
// Multiply/divide unit for the P7 E stage: owns HI/LO, runs mult/div over a fixed
// busy latency and serves mfhi/mflo/mthi/mtlo.
module mdu_unit #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Req,
    output logic        start,
    output logic        BUSY,
    output logic [31:0] MDdata
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int unsigned LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [31:0]        hi_p;
    logic [31:0]        lo_p;
    logic               wr_p;

    logic signed [63:0] a_s;
    logic signed [63:0] b_s;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        den_s;
    logic [31:0]        den_u;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        q_s;
    logic [31:0]        r_s;
    logic [31:0]        q_u;
    logic [31:0]        r_u;
    logic               is_div;
    logic               div_zero;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    assign start  = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU) && !Req;
    assign BUSY   = (state == RUN);
    assign MDdata = (MDUOp == OP_MFHI) ? hi : ((MDUOp == OP_MFLO) ? lo : 32'd0);

    // Products: both operands widened so the low 64 bits are the exact product.
    assign a_s    = 64'($signed(A));
    assign b_s    = 64'($signed(B));
    assign prod_s = a_s * b_s;
    assign prod_u = 64'(A) * 64'(B);

    // Signed divide via magnitudes; quotient truncates toward zero, remainder takes dividend sign.
    assign a_mag  = A[31] ? -A : A;
    assign b_mag  = B[31] ? -B : B;
    assign den_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign den_u  = (B == 32'd0) ? 32'd1 : B;
    assign q_mag  = a_mag / den_s;
    assign r_mag  = a_mag % den_s;
    assign q_s    = (A[31] ^ B[31]) ? -q_mag : q_mag;
    assign r_s    = A[31] ? -r_mag : r_mag;
    assign q_u    = A / den_u;
    assign r_u    = A % den_u;

    assign is_div   = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    assign div_zero = is_div && (B == 32'd0);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (MDUOp)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
            OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
            default:  ;
        endcase
    end

    // Control FSM and HI/LO ownership; commit happens only on the last RUN edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            hi_p  <= 32'd0;
            lo_p  <= 32'd0;
            wr_p  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hi_p  <= res_hi;
                        lo_p  <= res_lo;
                        wr_p  <= !div_zero;
                        cnt   <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        state <= RUN;
                    end else if (!Req && (MDUOp == OP_MTHI)) begin
                        hi <= A;
                    end else if (!Req && (MDUOp == OP_MTLO)) begin
                        lo <= A;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (wr_p) begin
                            hi <= hi_p;
                            lo <= lo_p;
                        end
                        wr_p  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against an
// arithmetic reference model of HI/LO.
module tb_mdu_unit;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Req;
    logic        start;
    logic        BUSY;
    logic [31:0] MDdata;

    int checks;
    int failures;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .Req   (Req),
        .start (start),
        .BUSY  (BUSY),
        .MDdata(MDdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts and HI/LO writes are never issued while busy.
    always @(posedge clk) begin
        if (reset && BUSY) begin
            assert (!start && !(!Req && (MDUOp == 4'd7 || MDUOp == 4'd8)))
                else $error("illegal MDU issue while busy");
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: HI/LO result of an op from plain 64-bit arithmetic.
    function automatic void model_op(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] nhi,
                                     output logic [31:0] nlo, output logic wr);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        wr  = 1'b1;
        nhi = 32'd0;
        nlo = 32'd0;
        case (op)
            4'd1: begin sp = sa * sb; nhi = sp[63:32]; nlo = sp[31:0]; end
            4'd2: begin up = ua * ub; nhi = up[63:32]; nlo = up[31:0]; end
            4'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else begin sq = sa / sb; sr = sa % sb; nhi = sr[31:0]; nlo = sq[31:0]; end
            end
            4'd4: begin
                if (b == 32'd0) wr = 1'b0;
                else begin uq = ua / ub; ur = ua % ub; nhi = ur[31:0]; nlo = uq[31:0]; end
            end
            default: wr = 1'b0;
        endcase
    endfunction

    task automatic read_check(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        MDUOp = 4'd5;
        #1;
        check({tag, "_hi"}, 64'(MDdata), 64'(exp_hi));
        MDUOp = 4'd6;
        #1;
        check({tag, "_lo"}, 64'(MDdata), 64'(exp_lo));
        MDUOp = 4'd0;
        #1;
        check({tag, "_none"}, 64'(MDdata), 64'd0);
    endtask

    // Issue a mult/div op, then check BUSY over the whole latency window.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic req);
        int unsigned lat;
        logic        go, wr;
        logic [31:0] nhi, nlo;
        lat = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MULT_LAT;
        go  = !req;
        model_op(op, a, b, nhi, nlo, wr);
        MDUOp = op; A = a; B = b; Req = req;
        #1;
        check("start", 64'(start), 64'(go));
        tick();
        MDUOp = 4'd0;
        for (int i = 0; i < int'(lat); i++) begin
            Req = ($urandom_range(0, 3) == 0);
            A = $urandom;
            B = $urandom;
            check("busy", 64'(BUSY), 64'(go));
            tick();
        end
        Req = 1'b0;
        check("idle", 64'(BUSY), 64'd0);
        if (go && wr) begin
            m_hi = nhi;
            m_lo = nlo;
        end
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a, input logic req);
        MDUOp = op; A = a; B = $urandom; Req = req;
        #1;
        check("mv_start", 64'(start), 64'd0);
        tick();
        MDUOp = 4'd0; Req = 1'b0;
        if (!req) begin
            if (op == 4'd7) m_hi = a;
            else m_lo = a;
        end
    endtask

    task automatic reset_mid_div();
        logic [31:0] hold_hi, hold_lo;
        hold_hi = m_hi;
        hold_lo = m_lo;
        MDUOp = 4'd3; A = 32'hFFFFFF9C; B = 32'd7; Req = 1'b0;
        tick();
        MDUOp = 4'd0;
        for (int i = 1; i <= 4; i++) begin
            check("rst_busy", 64'(BUSY), 64'd1);
            if (i == 4) reset = 1'b0;
            tick();
        end
        reset = 1'b1;
        check("rst_clear", 64'(BUSY), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        if (hold_hi == 32'd0 && hold_lo == 32'd0) m_lo = 32'd0;
        for (int i = 0; i < int'(DIV_LAT) + 2; i++) begin
            check("rst_quiet", 64'(BUSY), 64'd0);
            tick();
        end
        read_check("rst", 32'd0, 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        reset = 1'b0;
        A = 32'd0; B = 32'd0; MDUOp = 4'd0; Req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_busy0", 64'(BUSY), 64'd0);
        check("rst_start0", 64'(start), 64'd0);
        read_check("rst0", 32'd0, 32'd0);

        // Spec scenarios.
        run_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
        read_check("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        read_check("multu", 32'h00000001, 32'hFFFFFFFE);
        run_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        read_check("mult_m1", 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        read_check("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(4'd4, 32'd7, 32'd2, 1'b0);
        read_check("divu", 32'd1, 32'd3);
        move_to(4'd7, 32'h12345678, 1'b0);
        read_check("mthi", 32'h12345678, 32'd3);
        run_op(4'd4, 32'd7, 32'd0, 1'b0);
        read_check("divu_z", 32'h12345678, 32'd3);
        run_op(4'd1, 32'd9, 32'd9, 1'b1);
        read_check("mult_req", 32'h12345678, 32'd3);
        move_to(4'd8, 32'hDEADBEEF, 1'b1);
        read_check("mtlo_req", 32'h12345678, 32'd3);
        move_to(4'd8, 32'hCAFEF00D, 1'b0);
        read_check("mtlo", 32'h12345678, 32'hCAFEF00D);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        read_check("div_ovf", m_hi, m_lo);
        reset_mid_div();

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            logic        req;
            op  = 4'($urandom_range(1, 6));
            a   = $urandom;
            b   = $urandom;
            req = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (op <= 4'd4) run_op(op, a, b, req);
            else move_to((op == 4'd5) ? 4'd7 : 4'd8, a, req);
            read_check("rand", m_hi, m_lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
